// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit.
//   RESULT_SRC_MEM : ResultSrc encoding that marks a load. It must stay in step
//                    with the decoder's ResultSrc encoding in ControlTypeDefs.svh.
//   FWD_*          : operand forwarding select encodings.
//   hazard_state_t : hazard FSM states.
package hazard_pkg;

    localparam logic [2:0] RESULT_SRC_MEM = 3'b001;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic {
        RUN         = 1'b0,
        MULDIV_BUSY = 1'b1
    } hazard_state_t;

    // A later-stage write satisfies a source read only if it really writes
    // and does not target x0.
    function automatic logic reg_match(input logic [4:0] rs, input logic [4:0] rd,
                                       input logic we);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline datapath and the hazard control unit.
//   master : pipeline side; drives register/control info, receives stall/flush/forward.
//   slave  : hazard control unit.
// Signals: iRs1D/iRs2D, iRs1E/iRs2E, iRdE, iResultSrcE, iRegWriteEnE,
//          iMulDivStartE, iPCSrcE, iRdM/iRdW, iRegWriteEnM/W (to the unit);
//          oStallF, oStallD, oFlushD, oFlushE, oForwardAE/BE, oBusyE (from it).
interface hazard_control_unit_if;

    logic [4:0] iRs1D, iRs2D;
    logic [4:0] iRs1E, iRs2E;
    logic [4:0] iRdE;
    logic [2:0] iResultSrcE;
    logic       iRegWriteEnE;
    logic       iMulDivStartE;
    logic       iPCSrcE;
    logic [4:0] iRdM, iRdW;
    logic       iRegWriteEnM, iRegWriteEnW;

    logic       oStallF, oStallD;
    logic       oFlushD, oFlushE;
    logic [1:0] oForwardAE, oForwardBE;
    logic       oBusyE;

    modport master (
        output iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iResultSrcE, iRegWriteEnE,
               iMulDivStartE, iPCSrcE, iRdM, iRdW, iRegWriteEnM, iRegWriteEnW,
        input  oStallF, oStallD, oFlushD, oFlushE, oForwardAE, oForwardBE, oBusyE
    );

    modport slave (
        input  iRs1D, iRs2D, iRs1E, iRs2E, iRdE, iResultSrcE, iRegWriteEnE,
               iMulDivStartE, iPCSrcE, iRdM, iRdW, iRegWriteEnM, iRegWriteEnW,
        output oStallF, oStallD, oFlushD, oFlushE, oForwardAE, oForwardBE, oBusyE
    );

endinterface

// File: rtl/hazard_control_unit_forward_select.sv
// forward_select: forwarding mux select for one E-stage source operand.
//   iRs                       : source register in E
//   iRdM, iRegWriteEnM        : M-stage destination / write enable
//   iRdW, iRegWriteEnW        : W-stage destination / write enable
//   oSel                      : FWD_MEM, FWD_WB or FWD_NONE
// M is the younger result, so it takes priority over W.
module forward_select
    import hazard_pkg::*;
(
    input  logic [4:0] iRs,
    input  logic [4:0] iRdM,
    input  logic       iRegWriteEnM,
    input  logic [4:0] iRdW,
    input  logic       iRegWriteEnW,
    output logic [1:0] oSel
);

    always_comb begin
        oSel = FWD_NONE;
        if (reg_match(iRs, iRdM, iRegWriteEnM))
            oSel = FWD_MEM;
        else if (reg_match(iRs, iRdW, iRegWriteEnW))
            oSel = FWD_WB;
    end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall / flush / forwarding control for the pipeline.
//   iClk, iRst : clock (rising edge), asynchronous active-high reset
//   hz         : hazard_control_unit_if.slave bundle (see interface header)
//   oStallCount, oFlushCount : performance counters, present only when
//                              HAZARD_PERF_CNT_EN is defined
// Load-use hazards stall F/D for one cycle and bubble E. A MUL/DIV start moves
// the FSM to MULDIV_BUSY, which holds F/D and bubbles E for MULDIV_LATENCY-1
// cycles. A taken branch/jump in E flushes D and E and overrides stalls.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MULDIV_LATENCY = 4
`ifdef HAZARD_PERF_CNT_EN
   ,parameter int CNT_W          = 32
`endif
) (
    input  logic                  iClk,
    input  logic                  iRst,
    hazard_control_unit_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [CNT_W-1:0]      oStallCount
   ,output logic [CNT_W-1:0]      oFlushCount
`endif
);

    localparam int BW = (MULDIV_LATENCY > 2) ? $clog2(MULDIV_LATENCY) : 1;
    localparam logic [BW-1:0] BUSY_LOAD = BW'(MULDIV_LATENCY - 2);

    hazard_state_t state, state_nx;
    logic [BW-1:0] busy_cnt;

    logic [1:0] fwd_a, fwd_b;
    logic       load_use;
    logic       stall_f, stall_d, flush_d, flush_e, busy;

    forward_select u_fwd_a (
        .iRs          (hz.iRs1E),
        .iRdM         (hz.iRdM),
        .iRegWriteEnM (hz.iRegWriteEnM),
        .iRdW         (hz.iRdW),
        .iRegWriteEnW (hz.iRegWriteEnW),
        .oSel         (fwd_a)
    );

    forward_select u_fwd_b (
        .iRs          (hz.iRs2E),
        .iRdM         (hz.iRdM),
        .iRegWriteEnM (hz.iRegWriteEnM),
        .iRdW         (hz.iRdW),
        .iRegWriteEnW (hz.iRegWriteEnW),
        .oSel         (fwd_b)
    );

    assign load_use = (hz.iResultSrcE == RESULT_SRC_MEM) &&
                      (reg_match(hz.iRs1D, hz.iRdE, hz.iRegWriteEnE) ||
                       reg_match(hz.iRs2D, hz.iRdE, hz.iRegWriteEnE));

    // State register and bubble counter.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= RUN;
            busy_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == RUN) begin
                if (state_nx == MULDIV_BUSY)
                    busy_cnt <= BUSY_LOAD;
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - BW'(1);
            end
        end
    end

    // Next state. A redirect in RUN kills the MUL/DIV op before it starts.
    always_comb begin
        state_nx = state;
        case (state)
            RUN:         if (hz.iMulDivStartE && !hz.iPCSrcE) state_nx = MULDIV_BUSY;
            MULDIV_BUSY: if (busy_cnt == '0)                  state_nx = RUN;
            default:     state_nx = RUN;
        endcase
    end

    // Outputs. Reset forces bubbles into D and E so nothing half-formed advances.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        busy    = 1'b0;
        if (iRst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (state == MULDIV_BUSY) begin
            // E holds bubbles here, so iPCSrcE is meaningless and ignored.
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            busy    = 1'b1;
        end else if (hz.iPCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.oStallF    = stall_f;
    assign hz.oStallD    = stall_d;
    assign hz.oFlushD    = flush_d;
    assign hz.oFlushE    = flush_e;
    assign hz.oBusyE     = busy;
    assign hz.oForwardAE = iRst ? FWD_NONE : fwd_a;
    assign hz.oForwardBE = iRst ? FWD_NONE : fwd_b;

`ifdef HAZARD_PERF_CNT_EN
    // Saturating event counters.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oStallCount <= '0;
            oFlushCount <= '0;
        end else begin
            if (stall_d && !(&oStallCount))
                oStallCount <= oStallCount + CNT_W'(1);
            if (hz.iPCSrcE && !(&oFlushCount))
                oFlushCount <= oFlushCount + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit. A behavioural model counts
// remaining bubble cycles as an integer and derives the expected outputs from
// the stall/flush/forward rules; random and directed stimulus is checked
// against it every cycle. Perf counter checks build with HAZARD_PERF_CNT_EN.
module tb_hazard_control_unit;

    localparam int LAT = 4;

    logic iClk = 1'b0;
    logic iRst = 1'b0;
    always #5 iClk = ~iClk;

    hazard_control_unit_if hif();

`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] oStallCount, oFlushCount;
    hazard_control_unit #(.MULDIV_LATENCY(LAT), .CNT_W(4)) dut (
        .iClk(iClk), .iRst(iRst), .hz(hif),
        .oStallCount(oStallCount), .oFlushCount(oFlushCount));
`else
    hazard_control_unit #(.MULDIV_LATENCY(LAT)) dut (
        .iClk(iClk), .iRst(iRst), .hz(hif));
`endif

    int total = 0;
    int bad   = 0;
    int bl    = 0;   // model: bubble cycles still owed by a MUL/DIV op
    int ms    = 0;   // model: stall cycles seen (saturating at 15)
    int mf    = 0;   // model: redirect cycles seen (saturating at 15)

    // Expected forward select from the spec rules.
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (hif.iRegWriteEnM && hif.iRdM != 0 && hif.iRdM == rs) return 2'b10;
        if (hif.iRegWriteEnW && hif.iRdW != 0 && hif.iRdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected {stallF, stallD, flushD, flushE, fwdA, fwdB, busy}.
    function automatic logic [8:0] m_out();
        logic sf, sd, fd, fe, bz, lu;
        sf = 0; sd = 0; fd = 0; fe = 0; bz = 0;
        lu = hif.iResultSrcE == 3'b001 && hif.iRegWriteEnE && hif.iRdE != 0 &&
             (hif.iRdE == hif.iRs1D || hif.iRdE == hif.iRs2D);
        if (bl > 0) begin sf = 1; sd = 1; fe = 1; bz = 1; end
        else if (hif.iPCSrcE) begin fd = 1; fe = 1; end
        else if (lu) begin sf = 1; sd = 1; fe = 1; end
        return {sf, sd, fd, fe, m_fwd(hif.iRs1E), m_fwd(hif.iRs2E), bz};
    endfunction

    function automatic logic [8:0] act();
        return {hif.oStallF, hif.oStallD, hif.oFlushD, hif.oFlushE,
                hif.oForwardAE, hif.oForwardBE, hif.oBusyE};
    endfunction

    // Advance the model across the coming rising edge.
    task automatic m_step();
        logic [8:0] e;
        e = m_out();
        if (e[7] && ms < 15) ms++;
        if (hif.iPCSrcE && mf < 15) mf++;
        if (bl > 0) bl--;
        else if (hif.iMulDivStartE && !hif.iPCSrcE) bl = LAT - 1;
    endtask

    task automatic drive_idle();
        hif.iRs1D = 0; hif.iRs2D = 0; hif.iRs1E = 0; hif.iRs2E = 0; hif.iRdE = 0;
        hif.iResultSrcE = 0; hif.iRegWriteEnE = 0; hif.iMulDivStartE = 0;
        hif.iPCSrcE = 0; hif.iRdM = 0; hif.iRdW = 0;
        hif.iRegWriteEnM = 0; hif.iRegWriteEnW = 0;
    endtask

    task automatic drive_random();
        hif.iRs1D = 5'($urandom_range(0, 7)); hif.iRs2D = 5'($urandom_range(0, 7));
        hif.iRs1E = 5'($urandom_range(0, 7)); hif.iRs2E = 5'($urandom_range(0, 7));
        hif.iRdE  = 5'($urandom_range(0, 7));
        hif.iRdM  = 5'($urandom_range(0, 7)); hif.iRdW = 5'($urandom_range(0, 7));
        hif.iResultSrcE  = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
        hif.iRegWriteEnE = 1'($urandom_range(0, 1));
        hif.iRegWriteEnM = 1'($urandom_range(0, 1));
        hif.iRegWriteEnW = 1'($urandom_range(0, 1));
        hif.iMulDivStartE = ($urandom_range(0, 5) == 0);
        hif.iPCSrcE       = ($urandom_range(0, 4) == 0);
    endtask

    task automatic test_reset();
        drive_idle();
        hif.iRs1E = 5; hif.iRdM = 5; hif.iRegWriteEnM = 1; hif.iMulDivStartE = 1;
        @(negedge iClk); #2;
        iRst = 1; #1;
        total++;
        if (act() !== 9'b001100000) begin
            bad++; $display("FAIL reset_assert got=%b exp=%b", act(), 9'b001100000);
        end
        @(posedge iClk); #1;
        total++;
        if (act() !== 9'b001100000) begin
            bad++; $display("FAIL reset_hold got=%b exp=%b", act(), 9'b001100000);
        end
        bl = 0; ms = 0; mf = 0;
        @(negedge iClk);
        iRst = 0; drive_idle(); #1;
        total++;
        if (act() !== 9'b0) begin
            bad++; $display("FAIL reset_release got=%b exp=%b", act(), 9'b0);
        end
        m_step();
    endtask

    task automatic test_forwarding();
        @(negedge iClk); drive_idle();
        hif.iRs1E = 5; hif.iRdM = 5; hif.iRdW = 5;
        hif.iRegWriteEnM = 1; hif.iRegWriteEnW = 1; #1;
        total++;
        if (hif.oForwardAE !== 2'b10) begin
            bad++; $display("FAIL fwd_mem got=%b exp=10", hif.oForwardAE);
        end
        hif.iRdM = 0; #1;
        total++;
        if (hif.oForwardAE !== 2'b01) begin
            bad++; $display("FAIL fwd_wb got=%b exp=01", hif.oForwardAE);
        end
        hif.iRs2E = 0; hif.iRdW = 0; hif.iRegWriteEnW = 1; #1;
        total++;
        if (hif.oForwardBE !== 2'b00) begin
            bad++; $display("FAIL fwd_x0 got=%b exp=00", hif.oForwardBE);
        end
        m_step();
        for (int i = 0; i < 40; i++) begin
            @(negedge iClk); drive_random(); hif.iMulDivStartE = 0; hif.iPCSrcE = 0; #1;
            total++;
            if (act() !== m_out()) begin
                bad++; $display("FAIL fwd_rand i=%0d got=%b exp=%b", i, act(), m_out());
            end
            m_step();
        end
    endtask

    task automatic test_load_use();
        @(negedge iClk); drive_idle();
        hif.iResultSrcE = 3'b001; hif.iRegWriteEnE = 1; hif.iRdE = 7; hif.iRs2D = 7; #1;
        total++;
        if (act() !== 9'b110100000) begin
            bad++; $display("FAIL load_use got=%b exp=%b", act(), 9'b110100000);
        end
        m_step();
        @(negedge iClk); hif.iRdE = 0; hif.iRs2D = 0; #1;
        total++;
        if (act() !== 9'b0) begin
            bad++; $display("FAIL load_use_x0 got=%b exp=%b", act(), 9'b0);
        end
        m_step();
    endtask

    task automatic test_muldiv();
        int busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge iClk); drive_idle();
            hif.iMulDivStartE = (i == 0 || i == 2);
            #1;
            if (hif.oBusyE === 1'b1) busy_cycles++;
            total++;
            if (act() !== m_out()) begin
                bad++; $display("FAIL muldiv i=%0d got=%b exp=%b", i, act(), m_out());
            end
            m_step();
        end
        total++;
        if (busy_cycles != LAT - 1) begin
            bad++; $display("FAIL muldiv_len got=%0d exp=%0d", busy_cycles, LAT - 1);
        end
    endtask

    task automatic test_redirect();
        @(negedge iClk); drive_idle();
        hif.iPCSrcE = 1; hif.iResultSrcE = 3'b001; hif.iRegWriteEnE = 1;
        hif.iRdE = 3; hif.iRs1D = 3; #1;
        total++;
        if (act() !== 9'b001100000) begin
            bad++; $display("FAIL redirect_lu got=%b exp=%b", act(), 9'b001100000);
        end
        m_step();
        @(negedge iClk); drive_idle(); hif.iPCSrcE = 1; hif.iMulDivStartE = 1; #1;
        m_step();
        @(negedge iClk); drive_idle(); #1;
        total++;
        if (act() !== 9'b0) begin
            bad++; $display("FAIL redirect_muldiv got=%b exp=%b", act(), 9'b0);
        end
        m_step();
    endtask

    task automatic test_reset_mid_busy();
        @(negedge iClk); drive_idle(); hif.iMulDivStartE = 1; #1; m_step();
        @(negedge iClk); drive_idle(); #1;
        total++;
        if (hif.oBusyE !== 1'b1) begin
            bad++; $display("FAIL busy_before_rst got=%b exp=1", hif.oBusyE);
        end
        #1; iRst = 1; #1;
        total++;
        if (act() !== 9'b001100000) begin
            bad++; $display("FAIL rst_mid_busy got=%b exp=%b", act(), 9'b001100000);
        end
        bl = 0; ms = 0; mf = 0;
        @(negedge iClk); iRst = 0; #1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge iClk); #1; end
            total++;
            if (act() !== 9'b0) begin
                bad++; $display("FAIL after_rst_busy i=%0d got=%b exp=%b", i, act(), 9'b0);
            end
            m_step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge iClk); drive_random(); #1;
            total++;
            if (act() !== m_out()) begin
                bad++; $display("FAIL rand i=%0d got=%b exp=%b", i, act(), m_out());
            end
            m_step();
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        @(negedge iClk); drive_idle(); iRst = 1; bl = 0; ms = 0; mf = 0;
        @(negedge iClk); iRst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge iClk); drive_idle(); hif.iMulDivStartE = (i == 0); #1; m_step();
        end
        @(negedge iClk); drive_idle(); #1;
        total++;
        if (oStallCount !== 4'd3) begin
            bad++; $display("FAIL perf_stall got=%0d exp=3", oStallCount);
        end
        m_step();
        for (int i = 0; i < 2; i++) begin
            @(negedge iClk); drive_idle(); hif.iPCSrcE = 1; #1; m_step();
        end
        @(negedge iClk); drive_idle(); #1;
        total++;
        if (oFlushCount !== 4'd2) begin
            bad++; $display("FAIL perf_flush got=%0d exp=2", oFlushCount);
        end
        m_step();
        for (int i = 0; i < 20; i++) begin
            @(negedge iClk); drive_idle();
            hif.iResultSrcE = 3'b001; hif.iRegWriteEnE = 1; hif.iRdE = 9; hif.iRs1D = 9;
            #1; m_step();
        end
        @(negedge iClk); drive_idle(); #1;
        total++;
        if (oStallCount !== 4'(ms) || ms != 15) begin
            bad++; $display("FAIL perf_sat got=%0d exp=15", oStallCount);
        end
        m_step();
    endtask
`endif

    initial begin
        drive_idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_muldiv();
        test_redirect();
        test_reset_mid_busy();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
